// File: rtl/ssm_dispatch_fsm.sv
// Instruction fetch/dispatch controller: fetches, decodes and hands each SSM instruction to one of four execution FSMs.
// Optional watchdog on the EXEC wait is enabled by defining DISPATCH_TIMEOUT_EN.
module ssm_dispatch_fsm #(
  parameter int PC_WIDTH       = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                run,
  output logic [PC_WIDTH-1:0] instr_addr,
  output logic                instr_rd_en,
  input  logic [17:0]         instr_data,
  output logic [3:0]          FSM_start,
  output logic [5:0]          param1,
  output logic [5:0]          param2,
  input  logic [3:0]          fsm_done,
  output logic [PC_WIDTH-1:0] pc,
  output logic                busy,
  output logic                halted,
  output logic                illegal,
  output logic                timeout
);

  localparam logic [5:0] OP_NOP  = 6'h00;
  localparam logic [5:0] OP_MOV  = 6'h01;
  localparam logic [5:0] OP_ADD  = 6'h02;
  localparam logic [5:0] OP_SUB  = 6'h03;
  localparam logic [5:0] OP_XOR  = 6'h04;
  localparam logic [5:0] OP_HALT = 6'h3F;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_START,
    S_EXEC,
    S_HALT
  } state_t;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [5:0]          param1_q, param1_d;
  logic [5:0]          param2_q, param2_d;
  logic [1:0]          sel_q, sel_d;
  logic [3:0]          start_q, start_d;
  logic                rd_en_q, rd_en_d;
  logic                busy_q, busy_d;
  logic                halted_q, halted_d;
  logic                illegal_q, illegal_d;
  logic [5:0]          op_m1;

`ifdef DISPATCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
`endif

  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    param1_d  = param1_q;
    param2_d  = param2_q;
    sel_d     = sel_q;
    illegal_d = illegal_q;
    op_m1     = instr_data[17:12] - 6'd1;
`ifdef DISPATCH_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
`endif

    unique case (state_q)
      S_IDLE:  if (run) state_d = S_FETCH;
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        param1_d = instr_data[11:6];
        param2_d = instr_data[5:0];
        case (instr_data[17:12])
          OP_NOP: begin
            pc_d    = pc_q + PC_WIDTH'(1);
            state_d = run ? S_FETCH : S_IDLE;
          end
          OP_HALT: state_d = S_HALT;
          OP_MOV, OP_ADD, OP_SUB, OP_XOR: begin
            sel_d   = op_m1[1:0];
            state_d = S_START;
          end
          default: begin
            illegal_d = 1'b1;
            state_d   = S_HALT;
          end
        endcase
      end
      S_START: begin
        state_d = S_EXEC;
`ifdef DISPATCH_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_EXEC: begin
        // Only the selected FSM's done can retire the instruction.
        if (fsm_done[sel_q]) begin
          pc_d    = pc_q + PC_WIDTH'(1);
          state_d = run ? S_FETCH : S_IDLE;
        end
`ifdef DISPATCH_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so they are computed from the state being entered.
    rd_en_d  = (state_d == S_FETCH);
    start_d  = (state_d == S_START) ? (4'b0001 << sel_d) : 4'b0000;
    busy_d   = (state_d != S_IDLE) && (state_d != S_HALT);
    halted_d = (state_d == S_HALT);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      param1_q  <= '0;
      param2_q  <= '0;
      sel_q     <= '0;
      start_q   <= '0;
      rd_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
`ifdef DISPATCH_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      param1_q  <= param1_d;
      param2_q  <= param2_d;
      sel_q     <= sel_d;
      start_q   <= start_d;
      rd_en_q   <= rd_en_d;
      busy_q    <= busy_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
`ifdef DISPATCH_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign instr_addr  = pc_q;
  assign pc          = pc_q;
  assign instr_rd_en = rd_en_q;
  assign FSM_start   = start_q;
  assign param1      = param1_q;
  assign param2      = param2_q;
  assign busy        = busy_q;
  assign halted      = halted_q;
  assign illegal     = illegal_q;
`ifdef DISPATCH_TIMEOUT_EN
  assign timeout     = timeout_q;
`else
  assign timeout     = 1'b0;
`endif

endmodule
